// File: rtl/maple_data_decoder_if.sv
// Bus-facing signal bundle for the Maple data decoder.
// The master side is the bus controller / line driver; the slave side is the decoder.
interface maple_data_decoder_if;
  logic       enable;
  logic       sdcka;
  logic       sdckb;
  logic       full;
  logic       push;
  logic [7:0] data;
  logic       done;
  logic       busy;
  logic       overflow;
  logic       error;

  modport master (
    output enable, sdcka, sdckb, full,
    input  push, data, done, busy, overflow, error
  );

  modport slave (
    input  enable, sdcka, sdckb, full,
    output push, data, done, busy, overflow, error
  );
endinterface

// File: rtl/maple_data_decoder.sv
// Maple bus receive decoder: synchronizes SDCKA/SDCKB, decodes the alternating
// two-phase bit stream MSB first into bytes, pushes bytes into the RX FIFO and
// reports end-of-frame, overflow and protocol errors.
module maple_data_decoder #(
  parameter int SYNC_STAGES  = 2,
  parameter int IDLE_TIMEOUT = 16,
  parameter int TMR_W        = 5
) (
  input logic                 clk,
  input logic                 reset,
  maple_data_decoder_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_P1,
    S_WAIT_P2,
    S_DONE,
    S_ERROR
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] a_sync_q, a_sync_d;
  logic [SYNC_STAGES-1:0] b_sync_q, b_sync_d;
  logic                   a_hist_q, b_hist_q;
  logic [2:0]             cnt_q, cnt_d;
  logic [7:0]             sr_q, sr_d;
  logic [7:0]             data_q, data_d;
  logic [TMR_W-1:0]       tmr_q, tmr_d;
  logic                   push_q, push_d;
  logic                   done_q, done_d;
  logic                   busy_q, busy_d;
  logic                   overflow_q, overflow_d;
  logic                   error_q, error_d;

  logic a_s, b_s, fall_a, fall_b, bit_val, timeout, accept;

  assign a_s     = a_sync_q[SYNC_STAGES-1];
  assign b_s     = b_sync_q[SYNC_STAGES-1];
  assign fall_a  = a_hist_q & ~a_s;
  assign fall_b  = b_hist_q & ~b_s;
  // On an A fall the data rides on B, and vice versa.
  assign bit_val = fall_a ? b_s : a_s;
  assign timeout = busy_q && (tmr_q == TMR_W'(IDLE_TIMEOUT));

  assign bus.push     = push_q;
  assign bus.data     = data_q;
  assign bus.done     = done_q;
  assign bus.busy     = busy_q;
  assign bus.overflow = overflow_q;
  assign bus.error    = error_q;

  // Shift raw lines through the synchronizer chains.
  always_comb begin
    a_sync_d = {a_sync_q[SYNC_STAGES-2:0], bus.sdcka};
    b_sync_d = {b_sync_q[SYNC_STAGES-2:0], bus.sdckb};
  end

  // Idle timer: counts cycles with both lines high once a frame has started, saturating.
  always_comb begin
    tmr_d = tmr_q;
    if (!busy_q || !a_s || !b_s) begin
      tmr_d = '0;
    end else if (tmr_q != TMR_W'(IDLE_TIMEOUT)) begin
      tmr_d = tmr_q + TMR_W'(1);
    end
  end

  // Next-state, bit assembly and status flag logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sr_d       = sr_q;
    data_d     = data_q;
    push_d     = 1'b0;
    done_d     = 1'b0;
    busy_d     = busy_q;
    overflow_d = overflow_q;
    error_d    = error_q;
    accept     = 1'b0;

    if (!bus.enable) begin
      // Disarming drops any partial byte and clears the sticky flags.
      state_d    = S_IDLE;
      cnt_d      = '0;
      sr_d       = '0;
      busy_d     = 1'b0;
      overflow_d = 1'b0;
      error_d    = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_d   = '0;
          sr_d    = '0;
          busy_d  = 1'b0;
          state_d = S_WAIT_P1;
        end
        S_WAIT_P1: begin
          if (fall_b) begin
            state_d = S_ERROR;
            error_d = 1'b1;
            busy_d  = 1'b0;
          end else if (fall_a) begin
            accept  = 1'b1;
            state_d = S_WAIT_P2;
          end else if (timeout) begin
            busy_d = 1'b0;
            if (cnt_q == 3'd0) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = S_ERROR;
              error_d = 1'b1;
            end
          end
        end
        S_WAIT_P2: begin
          if (fall_a || timeout) begin
            state_d = S_ERROR;
            error_d = 1'b1;
            busy_d  = 1'b0;
          end else if (fall_b) begin
            accept  = 1'b1;
            state_d = S_WAIT_P1;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        S_ERROR: begin
          busy_d = 1'b0;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    if (accept) begin
      sr_d   = {sr_q[6:0], bit_val};
      cnt_d  = cnt_q + 3'd1;
      busy_d = 1'b1;
      if (cnt_q == 3'd7) begin
        if (bus.full) begin
          overflow_d = 1'b1;
        end else begin
          push_d = 1'b1;
          data_d = {sr_q[6:0], bit_val};
        end
      end
    end
  end

  // Register all state and outputs; lines idle high so synchronizers reset to 1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      a_sync_q   <= '1;
      b_sync_q   <= '1;
      a_hist_q   <= 1'b1;
      b_hist_q   <= 1'b1;
      cnt_q      <= '0;
      sr_q       <= '0;
      data_q     <= '0;
      tmr_q      <= '0;
      push_q     <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_sync_q   <= a_sync_d;
      b_sync_q   <= b_sync_d;
      a_hist_q   <= a_s;
      b_hist_q   <= b_s;
      cnt_q      <= cnt_d;
      sr_q       <= sr_d;
      data_q     <= data_d;
      tmr_q      <= tmr_d;
      push_q     <= push_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
      error_q    <= error_d;
    end
  end

endmodule
